// File: rtl/mult_pkg.sv
// Shared types and default geometry for the approximate multiplier's final adder stage.
package mult_pkg;

  localparam int MULT_W          = 32;
  localparam int MULT_SPLIT      = 16;
  localparam int MULT_APPROX_LSB = 8;

  typedef logic [MULT_W-1:0] mult_row_t;

  typedef struct packed {
    logic [MULT_SPLIT-1:0]        lo;
    logic                         c1;
    logic [MULT_W-MULT_SPLIT-1:0] s_hi;
    logic [MULT_W-MULT_SPLIT-1:0] c_hi;
    logic                         approx;
  } cpa_s1_t;

endpackage

// File: rtl/rca_seg.sv
// N-bit ripple-carry adder segment built from full-adder cells; purely combinational.
module rca_seg #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] cy;

  assign cy[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end

  assign cout = cy[N];

endmodule

// File: rtl/mult_cpa_pipe.sv
// Two-stage carry-propagate adder for the compressor tree's sum/carry rows, optional OR-approximated LSBs.
// Latency 2, 1 item/cycle; holds up to 2 items under backpressure, in_ready is combinational from out_ready.
module mult_cpa_pipe
  import mult_pkg::*;
#(
  parameter int W          = MULT_W,
  parameter int SPLIT      = MULT_SPLIT,
  parameter int APPROX_LSB = MULT_APPROX_LSB
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] row_s,
  input  logic [W-1:0] row_c,
  input  logic         approx_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] product,
  output logic         out_approx
);

  localparam int HI_W = W - SPLIT;
  localparam logic [SPLIT-1:0] OR_MASK = {SPLIT{1'b1}} >> (SPLIT - APPROX_LSB);

  cpa_s1_t           s1_q;
  logic              v1;
  logic              v2;
  logic              adv1;
  logic              adv2;
  logic [SPLIT-1:0]  or_bits;
  logic [SPLIT-1:0]  lo_a;
  logic [SPLIT-1:0]  lo_b;
  logic [SPLIT-1:0]  lo_sum;
  logic              lo_cout;
  logic [SPLIT-1:0]  lo_res;
  logic [HI_W-1:0]   hi_sum;
  logic              hi_cout_unused;

  assign adv2     = !v2 || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;
  assign out_valid = v2;

  // Zeroing the approximated bits before the adder kills their carry, so the
  // exact part above starts with cin=0 and those sum bits come out as 0.
  assign or_bits = approx_en ? OR_MASK : '0;
  assign lo_a    = row_s[SPLIT-1:0] & ~or_bits;
  assign lo_b    = row_c[SPLIT-1:0] & ~or_bits;
  assign lo_res  = lo_sum | ((row_s[SPLIT-1:0] | row_c[SPLIT-1:0]) & or_bits);

  rca_seg #(.N(SPLIT)) u_lo (
    .a    (lo_a),
    .b    (lo_b),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  rca_seg #(.N(HI_W)) u_hi (
    .a    (s1_q.s_hi),
    .b    (s1_q.c_hi),
    .cin  (s1_q.c1),
    .sum  (hi_sum),
    .cout (hi_cout_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      s1_q <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_q <= '{lo:     lo_res,
                  c1:     lo_cout,
                  s_hi:   row_s[W-1:SPLIT],
                  c_hi:   row_c[W-1:SPLIT],
                  approx: approx_en};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2         <= 1'b0;
      product    <= '0;
      out_approx <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        product    <= {hi_sum, s1_q.lo};
        out_approx <= s1_q.approx;
      end
    end
  end

endmodule

// File: tb/tb_mult_cpa_pipe.sv
// Directed and randomised checks of mult_cpa_pipe against hand-computed and modelled products.
module tb_mult_cpa_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] row_s;
  logic [31:0] row_c;
  logic        approx_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        out_approx;

  int errors;
  int checks;

  mult_cpa_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .row_s      (row_s),
    .row_c      (row_c),
    .approx_en  (approx_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .out_approx (out_approx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] s, input logic [31:0] c, input logic a);
    logic [7:0]  lo;
    logic [8:0]  mid;
    logic [15:0] hi;
    if (!a) return s + c;
    lo  = s[7:0] | c[7:0];
    mid = {1'b0, s[15:8]} + {1'b0, c[15:8]};
    hi  = s[31:16] + c[31:16] + {15'd0, mid[8]};
    return {hi, mid[7:0], lo};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair with out_ready=1 and report the product and accept-to-valid edge count.
  task automatic run_single(input logic [31:0] s, input logic [31:0] c, input logic a,
                            output logic [31:0] p, output logic ap, output int lat);
    row_s = s; row_c = c; approx_en = a; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    p  = product;
    ap = out_approx;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    row_s = '0; row_c = '0; approx_en = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (product !== 32'h0) begin errors++; $display("FAIL reset_product got=%h exp=00000000", product); end
    checks++; if (out_approx !== 1'b0) begin errors++; $display("FAIL reset_out_approx got=%b exp=0", out_approx); end
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_exact_carry();
    logic [31:0] p; logic ap; int lat;
    run_single(32'h0000FFFF, 32'h00000001, 1'b0, p, ap, lat);
    checks++; if (p !== 32'h00010000) begin errors++; $display("FAIL exact_carry_product got=%h exp=00010000", p); end
    checks++; if (ap !== 1'b0) begin errors++; $display("FAIL exact_carry_approx got=%b exp=0", ap); end
    checks++; if (lat != 2) begin errors++; $display("FAIL exact_carry_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_approx_low();
    logic [31:0] p; logic ap; int lat;
    run_single(32'h000000F0, 32'h00000010, 1'b1, p, ap, lat);
    checks++; if (p !== 32'h000000F0) begin errors++; $display("FAIL approx_low_product got=%h exp=000000f0", p); end
    checks++; if (ap !== 1'b1) begin errors++; $display("FAIL approx_low_flag got=%b exp=1", ap); end
    run_single(32'h000000F0, 32'h00000010, 1'b0, p, ap, lat);
    checks++; if (p !== 32'h00000100) begin errors++; $display("FAIL approx_off_product got=%h exp=00000100", p); end
    checks++; if (ap !== 1'b0) begin errors++; $display("FAIL approx_off_flag got=%b exp=0", ap); end
    run_single(32'h00FF00FF, 32'h00010101, 1'b1, p, ap, lat);
    checks++; if (p !== 32'h010001FF) begin errors++; $display("FAIL approx_mixed_product got=%h exp=010001ff", p); end
    run_single(32'h00FF00FF, 32'h00010101, 1'b0, p, ap, lat);
    checks++; if (p !== 32'h01000200) begin errors++; $display("FAIL exact_mixed_product got=%h exp=01000200", p); end
    // The OR segment must not carry into the exact bits.
    run_single(32'h0000FFFF, 32'h00000001, 1'b1, p, ap, lat);
    checks++; if (p !== 32'h0000FFFF) begin errors++; $display("FAIL approx_no_carry got=%h exp=0000ffff", p); end
  endtask

  task automatic test_wrap();
    logic [31:0] p; logic ap; int lat;
    run_single(32'hFFFFFFFF, 32'h00000001, 1'b0, p, ap, lat);
    checks++; if (p !== 32'h00000000) begin errors++; $display("FAIL wrap_product got=%h exp=00000000", p); end
    checks++; if ($isunknown(p) !== 1'b0) begin errors++; $display("FAIL wrap_x got=%h exp=no_x", p); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_extra_output got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    row_s = 32'h1; row_c = 32'h2; approx_en = 1'b0; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_a got=%b exp=1", in_ready); end
    step();
    row_s = 32'h100; row_c = 32'h100; approx_en = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_b got=%b exp=1", in_ready); end
    step();
    row_s = 32'hF0; row_c = 32'h10; approx_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready cyc=%0d got=%b exp=0", k, in_ready); end
      checks++; if (out_valid !== 1'b1 || product !== 32'h3) begin errors++; $display("FAIL bp_hold_a cyc=%0d got=%b/%h exp=1/00000003", k, out_valid, product); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || product !== 32'h200 || out_approx !== 1'b0) begin errors++; $display("FAIL bp_deliver_b got=%b/%h/%b exp=1/00000200/0", out_valid, product, out_approx); end
    step();
    checks++; if (out_valid !== 1'b1 || product !== 32'hF0 || out_approx !== 1'b1) begin errors++; $display("FAIL bp_deliver_c got=%b/%h/%b exp=1/000000f0/1", out_valid, product, out_approx); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    int stale;
    out_ready = 1'b0;
    row_s = 32'h1234; row_c = 32'h1111; approx_en = 1'b0; in_valid = 1'b1;
    step();
    row_s = 32'h5555; row_c = 32'h2222;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
    checks++; if (product !== 32'h0) begin errors++; $display("FAIL arst_product got=%h exp=00000000", product); end
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
    stale = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid !== 1'b0) stale++;
      step();
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL arst_stale got=%0d exp=0", stale); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vs [64];
    logic [31:0] vc [64];
    logic        va [64];
    logic [31:0] exp_p;
    for (int i = 0; i < 64; i++) begin
      vs[i] = $urandom;
      vc[i] = $urandom;
      va[i] = 1'($urandom_range(1));
    end
    out_ready = 1'b1;
    row_s = vs[0]; row_c = vc[0]; approx_en = va[0]; in_valid = 1'b1;
    for (int k = 1; k <= 65; k++) begin
      step();
      if (k >= 2) begin
        exp_p = model(vs[k-2], vc[k-2], va[k-2]);
        checks++;
        if (out_valid !== 1'b1 || product !== exp_p || out_approx !== va[k-2]) begin
          errors++;
          $display("FAIL b2b_item%0d got=%b/%h/%b exp=1/%h/%b", k - 2, out_valid, product, out_approx, exp_p, va[k-2]);
        end
      end
      if (k < 64) begin
        row_s = vs[k]; row_c = vc[k]; approx_en = va[k];
      end else begin
        in_valid = 1'b0;
      end
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra got=%b exp=0", out_valid); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_exact_carry();
    test_approx_low();
    test_wrap();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
